// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter of the multicycle MIPS system.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

  localparam int          TIMEOUT_DEF   = 15;
  localparam logic [31:0] ERR_RDATA_DEF = 32'h0;

  localparam logic M_CPU = 1'b0;
  localparam logic M_LDR = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; reused when more memory masters are added.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_idx
);

  assign grant_valid = req0 | req1;
  // On a tie the port that did not win most recently goes first.
  assign grant_idx   = (req0 & req1) ? ~last_owner : (req1 ? M_LDR : M_CPU);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the mips core (port 0) and the loader (port 1),
// sequencing each grant through IDLE -> BUSY -> DONE with a one-cycle ack and a wait timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            TIMEOUT   = TIMEOUT_DEF,
  parameter logic [DW-1:0] ERR_RDATA = DW'(ERR_RDATA_DEF)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          last_owner;
  logic          grant_valid;
  logic          grant_idx;

  rr_arbiter2 u_rr (
    .req0        (m0_req),
    .req1        (m1_req),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Memory-side outputs decode only registered state, so no req input reaches them combinationally.
  assign mem_en    = (state == BUSY);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);

  // NOTE: every register here, including both rdata holding registers, is assigned with <=
  // and cleared by reset so a reset mid-access leaves no stale ack, error or read data behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_owner <= M_LDR;
      owner      <= M_CPU;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner   <= grant_idx;
            we_q    <= (grant_idx == M_LDR) ? m1_we    : m0_we;
            addr_q  <= (grant_idx == M_LDR) ? m1_addr  : m0_addr;
            wdata_q <= (grant_idx == M_LDR) ? m1_wdata : m0_wdata;
            cnt     <= '0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!we_q) begin
              if (owner == M_LDR) m1_rdata <= mem_rdata;
              else                m0_rdata <= mem_rdata;
            end
            m0_ack <= (owner == M_CPU);
            m1_ack <= (owner == M_LDR);
            state  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
            // This BUSY cycle is the TIMEOUT-th one without an answer: abort the access.
            if (cnt == CW'(TIMEOUT - 1)) begin
              if (owner == M_LDR) m1_rdata <= ERR_RDATA;
              else                m0_rdata <= ERR_RDATA;
              m0_ack <= (owner == M_CPU);
              m1_ack <= (owner == M_LDR);
              m0_err <= (owner == M_CPU);
              m1_err <= (owner == M_LDR);
              state  <= DONE;
            end
          end
        end
        DONE: begin
          last_owner <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
